// File: rtl/key_matrix_scan.sv
// key_matrix_scan: scans an active-low push-button matrix, debounces press and
// release, and reports one encoded key per accepted press.
module key_matrix_scan #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int DEBOUNCE = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            scan_en,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_out,
   output logic [3:0]      key_code,
   output logic            key_valid,
   output logic            key_down
);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HOLD     = 2'd2
   } state_t;

   localparam logic [7:0] DB_TH    = 8'(DEBOUNCE);
   localparam logic [1:0] LAST_COL = 2'(COLS - 1);

   state_t          state_q, state_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [1:0]      phase_q, phase_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [1:0]      cand_row_q, cand_row_d;
   logic [1:0]      cand_col_q, cand_col_d;
   logic [3:0]      key_code_q, key_code_d;
   logic            key_valid_q, key_valid_d;
   logic            key_down_q, key_down_d;
   logic [COLS-1:0] col_out_q, col_out_d;

   logic [ROWS-1:0] row_s1_q, rs_q;
   logic [3:0]      rs_ext;
   logic            any_low;
   logic [1:0]      low_row;
   logic [7:0]      cnt_inc;
   logic [1:0]      next_col, cand_next_col;
   logic [3:0]      strobe4;

   // Two-flop synchronizer; idle level is all ones (pull-ups)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1_q <= '1;
         rs_q     <= '1;
      end else begin
         row_s1_q <= row_in;
         rs_q     <= row_s1_q;
      end
   end

   // Pad rows to 4 so a 2-bit row index is always in range; find lowest low row
   always_comb begin
      rs_ext = '1;
      rs_ext[ROWS-1:0] = rs_q;
      any_low = 1'b0;
      low_row = 2'd0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!rs_q[r]) begin
            any_low = 1'b1;
            low_row = 2'(r);
         end
      end
   end

   // Scan / debounce FSM next-state, counters and outputs
   always_comb begin
      state_d       = state_q;
      col_idx_d     = col_idx_q;
      phase_d       = phase_q;
      cnt_d         = cnt_q;
      cand_row_d    = cand_row_q;
      cand_col_d    = cand_col_q;
      key_code_d    = key_code_q;
      key_valid_d   = 1'b0;
      key_down_d    = key_down_q;
      cnt_inc       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      next_col      = (col_idx_q == LAST_COL) ? 2'd0 : col_idx_q + 2'd1;
      cand_next_col = (cand_col_q == LAST_COL) ? 2'd0 : cand_col_q + 2'd1;

      if (!scan_en) begin
         // Idle and blank; the last key code is kept for the consumer
         state_d    = SCAN;
         col_idx_d  = 2'd0;
         phase_d    = 2'd0;
         cnt_d      = 8'd0;
         key_down_d = 1'b0;
      end else begin
         case (state_q)
            SCAN: begin
               if (phase_q == 2'd2) begin
                  if (any_low) begin
                     // Column stays driven while the candidate is debounced
                     cand_row_d = low_row;
                     cand_col_d = col_idx_q;
                     cnt_d      = 8'd0;
                     state_d    = PRESS_DB;
                  end else begin
                     col_idx_d = next_col;
                     phase_d   = 2'd0;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
            PRESS_DB: begin
               if (!rs_ext[cand_row_q]) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_TH) begin
                     key_code_d  = 4'(int'(cand_row_q) * COLS + int'(cand_col_q));
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                     cnt_d       = 8'd0;
                     state_d     = HOLD;
                  end
               end else begin
                  // Bounce: give up on this key and move past its column
                  state_d   = SCAN;
                  col_idx_d = cand_next_col;
                  phase_d   = 2'd0;
                  cnt_d     = 8'd0;
               end
            end
            HOLD: begin
               // Only the accepted row matters; counter counts stable release
               if (rs_ext[cand_row_q]) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_TH) begin
                     key_down_d = 1'b0;
                     cnt_d      = 8'd0;
                     state_d    = SCAN;
                     col_idx_d  = cand_next_col;
                     phase_d    = 2'd0;
                  end
               end else begin
                  cnt_d = 8'd0;
               end
            end
            default: begin
               state_d   = SCAN;
               col_idx_d = 2'd0;
               phase_d   = 2'd0;
               cnt_d     = 8'd0;
            end
         endcase
      end

      // Strobe follows the column index it will be registered with
      strobe4   = ~(4'b0001 << col_idx_d);
      col_out_d = scan_en ? strobe4[COLS-1:0] : '1;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         phase_q     <= 2'd0;
         cnt_q       <= 8'd0;
         cand_row_q  <= 2'd0;
         cand_col_q  <= 2'd0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
         col_out_q   <= '1;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         cand_row_q  <= cand_row_d;
         cand_col_q  <= cand_col_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
         col_out_q   <= col_out_d;
      end
   end

   assign col_out   = col_out_q;
   assign key_code  = key_code_q;
   // Gate with scan_en so a pulse cannot be seen while the scanner is disabled
   assign key_valid = key_valid_q & scan_en;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: drives a modelled 4x4 key matrix; accepted keys are
// checked against a queue of expected codes.
module tb_key_matrix_scan;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scan_en;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   logic [3:0][3:0] keys;   // keys[row][col] = 1 when closed
   int exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   key_matrix_scan #(.ROWS(4), .COLS(4), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scan_en   (scan_en),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   always #5 clk = ~clk;

   // Matrix model: a row reads low when a closed key sits in a driven column
   always_comb begin
      for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r] & ~col_out);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_slot();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string tag, input int max);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (key_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, found, 1);
   endtask

   task automatic wait_up(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (!key_down) break;
      end
      chk(tag, key_down, 0);
   endtask

   // Scoreboard: every accepted key must match the oldest expected code
   always @(negedge clk) begin
      if (rst_n && key_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", key_valid, 0);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("key_code", key_code, e);
            chk("down_with_valid", key_down, 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e4;
      logic       seen;
      logic       found;
      int         lat;

      rst_n   = 1'b0;
      scan_en = 1'b0;
      keys    = '0;

      // Reset values
      @(negedge clk);
      chk("rst_col", col_out, 4'hF);
      chk("rst_code", key_code, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_down", key_down, 0);
      drive_slot();
      scan_en = 1'b1;
      rst_n   = 1'b1;

      // Idle scan pattern, aligned on the first column-1 strobe
      @(negedge clk);
      for (int i = 0; i < 20 && col_out !== 4'hD; i++) @(negedge clk);
      chk("idle_sync", col_out, 4'hD);
      for (int k = 0; k < 24; k++) begin
         e4 = ~(4'b0001 << ((k / 3 + 1) % 4));
         chk("idle_col", col_out, e4);
         @(negedge clk);
      end

      // Clean press of row 2 / col 1
      exp_q.push_back(9);
      drive_slot();
      keys[2][1] = 1'b1;
      wait_valid("press9_valid", 30);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold9_col", col_out, 4'hD);
      end
      chk("hold9_down", key_down, 1);
      chk("hold9_code", key_code, 9);
      drive_slot();
      keys[2][1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rel9_down_hi", key_down, 1);
      end
      @(negedge clk);
      chk("rel9_down_lo", key_down, 0);
      chk("rel9_resume", col_out, 4'hB);

      // Bouncing press of row 0 / col 3
      exp_q.push_back(3);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_slot();
         keys[0][3] = (i % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
         end
      end
      chk("bounce_quiet", seen, 0);
      wait_valid("bounce_valid", 40);
      drive_slot();
      keys[0][3] = 1'b0;
      wait_up("bounce_rel", 20);

      // Two keys in column 0, then a key in another column during hold
      exp_q.push_back(4);
      drive_slot();
      keys[1][0] = 1'b1;
      keys[3][0] = 1'b1;
      wait_valid("two_key_valid", 30);
      drive_slot();
      keys[3][0] = 1'b0;
      keys[0][2] = 1'b1;
      exp_q.push_back(2);
      repeat (12) @(negedge clk);
      chk("two_key_down", key_down, 1);
      chk("two_key_col", col_out, 4'hE);
      chk("two_key_code", key_code, 4);
      drive_slot();
      keys[1][0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rel4_down_hi", key_down, 1);
      end
      @(negedge clk);
      chk("rel4_down_lo", key_down, 0);
      chk("rel4_resume", col_out, 4'hD);
      wait_valid("other_col_valid", 20);
      drive_slot();
      keys[0][2] = 1'b0;
      wait_up("other_col_rel", 20);

      // scan_en drop while a key is held
      exp_q.push_back(9);
      drive_slot();
      keys[2][1] = 1'b1;
      wait_valid("en_press_valid", 30);
      repeat (3) @(negedge clk);
      drive_slot();
      scan_en = 1'b0;
      @(negedge clk);
      chk("en_drop_pre", key_down, 1);
      @(negedge clk);
      chk("en_drop_col", col_out, 4'hF);
      chk("en_drop_down", key_down, 0);
      chk("en_drop_code", key_code, 9);
      chk("en_drop_valid", key_valid, 0);
      repeat (5) @(negedge clk);
      chk("en_off_col", col_out, 4'hF);
      exp_q.push_back(9);
      drive_slot();
      scan_en = 1'b1;
      wait_valid("reen_valid", 40);
      drive_slot();
      keys[2][1] = 1'b0;
      wait_up("reen_rel", 20);

      // Asynchronous reset in the middle of a press debounce
      exp_q.push_back(6);
      drive_slot();
      keys[1][2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut.cnt_q == 8'd2 && !key_down) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_cnt2", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_col", col_out, 4'hF);
      chk("arst_down", key_down, 0);
      chk("arst_valid", key_valid, 0);
      chk("arst_code", key_code, 0);
      #1 rst_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (key_valid) begin
            lat = k;
            break;
         end
      end
      chk("rst_latency", lat, 13);
      drive_slot();
      keys[1][2] = 1'b0;
      wait_up("arst_rel", 20);

      repeat (4) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
